// File: rtl/flit_sender_if.sv
// Link-side bundle of flit_sender: FIFO head/counter/pull port plus the credit-gated output link.
`ifndef TAM_FLIT
`define TAM_FLIT 16
`endif
`ifndef TAM_BUFFER
`define TAM_BUFFER 4
`endif

interface flit_sender_if #(
  parameter int unsigned WIDTH = `TAM_FLIT,
  parameter int unsigned DEPTH = `TAM_BUFFER
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] head;
  logic [CNT_W-1:0] counter;
  logic             pull;
  logic             tx;
  logic [WIDTH-1:0] data_out;
  logic             credit_i;

  // master = the sender; slave = FIFO plus downstream link seen as one peer
  modport master (input head, counter, credit_i, output pull, tx, data_out);
  modport slave  (output head, counter, credit_i, input pull, tx, data_out);
endinterface

// File: rtl/flit_sender.sv
// Phoenix NoC output-link transmitter: drains a FIFO into a one-entry credit-gated link stage
// and tracks packet framing for eop/busy. Optional stall detector: SENDER_STALL_DET_EN.
`ifndef TAM_FLIT
`define TAM_FLIT 16
`endif
`ifndef TAM_BUFFER
`define TAM_BUFFER 4
`endif

module flit_sender #(
  parameter int unsigned WIDTH       = `TAM_FLIT,
  parameter int unsigned DEPTH       = `TAM_BUFFER,
  parameter int unsigned STALL_LIMIT = 255
) (
  input  logic          clock,
  input  logic          reset,
  flit_sender_if.master bus,
  output logic          eop,
  output logic          busy,
  output logic          stall_err
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {S_HEADER, S_SIZE, S_PAYLOAD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             tx_q, tx_d;
  logic             last_q, last_d;
  logic             eop_q, eop_d;
  logic             busy_q, busy_d;
  logic             load, acc, last_load;

  assign acc      = tx_q && bus.credit_i;
  assign load     = !reset && (bus.counter != CNT_W'(0)) && (!tx_q || bus.credit_i);
  assign bus.pull = load;

  assign bus.tx       = tx_q;
  assign bus.data_out = data_q;
  assign eop          = eop_q;
  assign busy         = busy_q;

  // State and output-stage registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_HEADER;
      remaining_q <= '0;
      data_q      <= '0;
      tx_q        <= 1'b0;
      last_q      <= 1'b0;
      eop_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      tx_q        <= tx_d;
      last_q      <= last_d;
      eop_q       <= eop_d;
      busy_q      <= busy_d;
    end
  end

  // Framing FSM: advances only when a flit is loaded into the output stage
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    last_load   = 1'b0;
    if (load) begin
      unique case (state_q)
        S_HEADER: state_d = S_SIZE;
        S_SIZE: begin
          remaining_d = bus.head;
          if (bus.head == '0) begin
            last_load = 1'b1;
            state_d   = S_HEADER;
          end else begin
            state_d = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (remaining_q != '0) remaining_d = remaining_q - WIDTH'(1);
          if (remaining_q == WIDTH'(1)) begin
            last_load = 1'b1;
            state_d   = S_HEADER;
          end
        end
        default: state_d = S_HEADER;
      endcase
    end
  end

  // Output stage: a load replaces the held flit even when it is being accepted
  always_comb begin
    tx_d   = tx_q;
    data_d = data_q;
    last_d = last_q;
    eop_d  = acc && last_q;
    busy_d = busy_q;
    if (acc && last_q) busy_d = 1'b0;
    if (load) begin
      tx_d   = 1'b1;
      data_d = bus.head;
      last_d = last_load;
      if (state_q == S_HEADER) busy_d = 1'b1;
    end else if (acc) begin
      tx_d = 1'b0;
    end
  end

`ifdef SENDER_STALL_DET_EN
  localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);

  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               stall_err_q;

  // Saturating count of consecutive credit-starved cycles with a flit pending
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!tx_q || acc) stall_cnt_d = '0;
    else if (stall_cnt_q != STALL_W'(STALL_LIMIT)) stall_cnt_d = stall_cnt_q + STALL_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      if (stall_cnt_d == STALL_W'(STALL_LIMIT)) stall_err_q <= 1'b1;
    end
  end

  assign stall_err = stall_err_q;
`else
  // Detector not built; the parameter is still referenced so both builds share one interface
  assign stall_err = 1'b0 & (STALL_LIMIT != 0);
`endif

endmodule

// File: doc/flit_sender.md
# flit_sender

Output-link transmitter for the Phoenix NoC router port. It drains flits from a `fifo_buffer` instance through that buffer's `head`/`counter`/`pull` interface. It drives them onto a credit-gated inter-router link through a one-entry registered output stage. It tracks packet framing (header, size, payload) so it can flag end-of-packet for the switch allocator.

## Interface
- `WIDTH`, default `` `TAM_FLIT ``: flit width in bits.
- `DEPTH`, default `` `TAM_BUFFER ``: depth of the feeding FIFO; sets the `counter` width.
- `STALL_LIMIT`, default 255: number of credit-stall cycles before `stall_err` fires. Used only with `SENDER_STALL_DET_EN`.
- `clock`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `head`  in  WIDTH  flit at the FIFO head; valid when `counter != 0`.
- `counter`  in  $clog2(DEPTH)+1  FIFO occupancy.
- `pull`  out  1  combinational FIFO pop request.
- `tx`  out  1  registered; the link flit `data_out` is valid.
- `data_out`  out  WIDTH  registered link flit.
- `credit_i`  in  1  downstream can accept a flit this cycle.
- `eop`  out  1  registered one-cycle pulse: the last flit of a packet was accepted by the link.
- `busy`  out  1  registered; high between header load and last-flit acceptance.
- `stall_err`  out  1  sticky credit-stall error flag.

## Operation
- Packet format:
  - flit 0 is the header;
  - flit 1 is the size, with payload count N taken as unsigned `WIDTH` bits;
  - flits 2..N+1 are the payload.
- Accept condition: `acc = tx && credit_i`.
- Load condition: `load = (counter != 0) && (!tx || credit_i)`. The block drives `pull = load`.
- On `load`:
  - `data_out <= head`;
  - `tx <= 1`;
  - the framing FSM advances.
- When `acc && !load`: `tx <= 0`. `data_out` holds its value.
- Framing FSM, evaluated on `load`:
  - `S_HEADER`: on load, go to `S_SIZE`; `busy <= 1`.
  - `S_SIZE`: on load, `remaining <= head`.
    - If `head == 0`, mark the flit last and go to `S_HEADER`.
    - Otherwise go to `S_PAYLOAD`.
  - `S_PAYLOAD`: on load, `remaining <= remaining - 1`.
    - If `remaining == 1`, mark the flit last and go to `S_HEADER`.
    - Otherwise stay in `S_PAYLOAD`.
- `last_q` is a register that travels with the output flit. It is set on a load that marks the flit last and cleared on any other load.
- On `acc && last_q`: `eop <= 1` for one cycle and `busy <= 0`.
  - If the same cycle also loads a new header, `busy` stays 1.
- Header flits are never last. The `remaining` register is `WIDTH` bits wide and never wraps; decrement happens only while it is ≥ 1.

## Timing
- Reset values:
  - `tx=0`, `data_out=0`, `eop=0`, `busy=0`, `stall_err=0`;
  - FSM in `S_HEADER`, `remaining=0`, `last_q=0`.
  - `pull` is 0 during reset (gated by reset).
- Latency: a flit present at `head` in cycle t appears on `data_out`/`tx` in cycle t+1.
- Throughput: 1 flit/cycle while `credit_i` stays high and the FIFO is non-empty.
- Credit low with `tx=1`: `data_out` and `tx` hold, and `pull=0`.
- Simultaneous accept and load: the new flit replaces the old one with no bubble.
- FIFO empty (`counter == 0`): `pull=0`. After the current flit is accepted, `tx` drops.
  - The FSM state is kept, so a packet may resume mid-payload.
- Reset mid-packet: everything returns to reset values on the next edge. The partial packet is abandoned.

## Configuration
- Macro: `SENDER_STALL_DET_EN`.
- Defined:
  - A stall counter increments each cycle with `tx && !credit_i`, saturating at `STALL_LIMIT`.
  - The counter clears on `acc` or when `tx=0`.
  - When the counter reaches `STALL_LIMIT`, `stall_err <= 1`. It is sticky until reset.
- Undefined: no counter logic is built, and `stall_err` is tied to 0.

## Test plan
- Reset, then preload the FIFO with header 0x11, size 0x02, payload 0xA0, 0xA1, with `credit_i=1`:
  - `data_out` = 0x11, 0x02, 0xA0, 0xA1 on consecutive cycles, starting one cycle after release;
  - `eop` pulses in the cycle after 0xA1 is accepted;
  - `busy` falls at the same edge.
- Packet with size 0x00: two flits are sent; `eop` follows the size flit; the FSM returns to `S_HEADER`.
- `credit_i=0` for 5 cycles mid-payload: `data_out` holds, `pull=0`, no flit is lost or duplicated, and the packet resumes on credit return.
- Two back-to-back packets with `credit_i=1`: no idle cycle between them; `eop` pulses exactly twice and `busy` stays 1 across the boundary.
- FIFO empties after the size flit (N=3): `tx` drops, `busy` stays 1. Refilling with 3 payload flits completes the packet and `eop` pulses.
- With `SENDER_STALL_DET_EN` defined and `STALL_LIMIT=4`, hold `credit_i=0` with `tx=1`:
  - `stall_err` rises on the 4th stall cycle;
  - it stays 1 after credit returns and until reset.
- With the macro undefined, the same stimulus gives `stall_err=0` throughout.
